// File: rtl/tick_gen_pkg.sv
// Shared defaults and helpers for the multi-channel tick generator.
package tick_gen_pkg;

  localparam int          N_CH_DEF    = 4;
  localparam int          DIV_W_DEF   = 26;
  localparam int unsigned DIV_RST_DEF = 50_000_000;

  // Channel-select width; a single channel still needs a 1-bit select port.
  function automatic int chWidth(input int nCh);
    return (nCh > 1) ? $clog2(nCh) : 1;
  endfunction

  localparam int CH_W_DEF = chWidth(N_CH_DEF);

  typedef logic [CH_W_DEF-1:0] chSel_t;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: divisor register, cycle counter, tick flop and, when
// TICKGEN_SQUARE_EN is defined, a square-wave flop toggled on every tick.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int          DIV_W   = DIV_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             ien,
  input  logic             isync,
  input  logic             iload,
  input  logic [DIV_W-1:0] idiv,
  output logic             otick
`ifdef TICKGEN_SQUARE_EN
  ,
  output logic             osq
`endif
);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;
  logic             wrap;

  // Equality is enough: every divisor change also clears cnt.
  assign wrap = ien && (cnt == div);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      div   <= DIV_W'(DIV_RST);
      cnt   <= '0;
      otick <= 1'b0;
    end else if (iload) begin
      div   <= idiv;
      cnt   <= '0;
      otick <= 1'b0;
    end else if (isync) begin
      cnt   <= '0;
      otick <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      otick <= 1'b1;
    end else if (ien) begin
      cnt   <= cnt + 1'b1;
      otick <= 1'b0;
    end else begin
      otick <= 1'b0;
    end
  end

`ifdef TICKGEN_SQUARE_EN
  logic sq;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      sq <= 1'b0;
    end else if (iload || isync) begin
      sq <= 1'b0;
    end else if (wrap) begin
      sq <= ~sq;
    end
  end

  assign osq = sq;
`else
  // Square-wave flop not built; otick is the only channel output.
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: N_CH independent programmable dividers with
// per-channel enable and global resync. Optional osq via TICKGEN_SQUARE_EN.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int          N_CH    = N_CH_DEF,
  parameter int          DIV_W   = DIV_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF,
  localparam int         CH_W    = chWidth(N_CH)
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic [N_CH-1:0]  ien,
  input  logic             isync,
  input  logic             iload,
  input  logic [CH_W-1:0]  ich,
  input  logic [DIV_W-1:0] idiv,
  output logic [N_CH-1:0]  otick
`ifdef TICKGEN_SQUARE_EN
  ,
  output logic [N_CH-1:0]  osq
`endif
);

  logic [N_CH-1:0] loadVec;

  for (genvar g = 0; g < N_CH; g++) begin : gChan
    // Select codes at or above N_CH match no channel, so such loads vanish.
    assign loadVec[g] = iload && (ich == CH_W'(g));

    tick_chan #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) uChan (
      .iclk  (iclk),
      .irst  (irst),
      .ien   (ien[g]),
      .isync (isync),
      .iload (loadVec[g]),
      .idiv  (idiv),
      .otick (otick[g])
`ifdef TICKGEN_SQUARE_EN
      ,
      .osq   (osq[g])
`endif
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Randomized and directed bench for tick_gen_multi against an elapsed-edge
// reference model; covers osq too when TICKGEN_SQUARE_EN is defined.
module tb_tick_gen_multi;

  localparam int N_CH    = 3;
  localparam int DIV_W   = 8;
  localparam int DIV_RST = 3;
  localparam int CH_W    = 2;

  logic             iclk = 1'b0;
  logic             irst;
  logic [N_CH-1:0]  ien;
  logic             isync;
  logic             iload;
  logic [CH_W-1:0]  ich;
  logic [DIV_W-1:0] idiv;
  logic [N_CH-1:0]  otick;
`ifdef TICKGEN_SQUARE_EN
  logic [N_CH-1:0]  osq;
`endif

  tick_gen_multi #(
    .N_CH    (N_CH),
    .DIV_W   (DIV_W),
    .DIV_RST (DIV_RST)
  ) dut (
    .iclk  (iclk),
    .irst  (irst),
    .ien   (ien),
    .isync (isync),
    .iload (iload),
    .ich   (ich),
    .idiv  (idiv),
    .otick (otick)
`ifdef TICKGEN_SQUARE_EN
    ,
    .osq   (osq)
`endif
  );

  always #5 iclk = ~iclk;

  int passCnt  = 0;
  int checkCnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
  endtask

  // Model: each channel remembers its divisor and how many enabled edges have
  // elapsed since its counter was last cleared. A tick lands on every
  // (div+1)th such edge; the square wave is the parity of ticks so far.
  int              mDiv [N_CH];
  int              mN   [N_CH];
  logic [N_CH-1:0] expTick;
  logic [N_CH-1:0] expSq;

  task automatic modelReset();
    for (int i = 0; i < N_CH; i++) begin
      mDiv[i] = DIV_RST;
      mN[i]   = 0;
    end
    expTick = '0;
    expSq   = '0;
  endtask

  task automatic modelEdge();
    for (int i = 0; i < N_CH; i++) begin
      if (iload && int'(ich) == i) begin
        mDiv[i] = int'(idiv);
        mN[i]   = 0;
        expTick[i] = 1'b0;
      end else if (isync) begin
        mN[i] = 0;
        expTick[i] = 1'b0;
      end else if (ien[i]) begin
        mN[i]++;
        expTick[i] = (mN[i] % (mDiv[i] + 1)) == 0;
      end else begin
        expTick[i] = 1'b0;
      end
      expSq[i] = ((mN[i] / (mDiv[i] + 1)) % 2) == 1;
    end
  endtask

  // One clock: inputs already driven after a falling edge; model follows the
  // rising edge, outputs are compared on the next falling edge.
  task automatic step(input string tag);
    @(posedge iclk);
    modelEdge();
    @(negedge iclk);
    check({tag, ".otick"}, 32'(otick), 32'(expTick));
`ifdef TICKGEN_SQUARE_EN
    check({tag, ".osq"}, 32'(osq), 32'(expSq));
`endif
    iload = 1'b0;
    isync = 1'b0;
  endtask

  task automatic loadCh(input int ch, input int dv, input string tag);
    iload = 1'b1;
    ich   = CH_W'(ch);
    idiv  = DIV_W'(dv);
    step(tag);
  endtask

  initial begin
    irst  = 1'b0;
    ien   = '1;
    isync = 1'b0;
    iload = 1'b0;
    ich   = '0;
    idiv  = '0;
    modelReset();

    // Held in reset: outputs stay low across edges.
    for (int k = 0; k < 3; k++) begin
      @(negedge iclk);
      check("rst.otick", 32'(otick), 32'd0);
`ifdef TICKGEN_SQUARE_EN
      check("rst.osq", 32'(osq), 32'd0);
`endif
    end
    irst = 1'b1;

    // Default divisor 3: first tick on the 4th edge after release.
    for (int k = 0; k < 12; k++) step("div_rst");

    // ch1 to div 0: ticks every cycle from the next edge; ch0 unaffected.
    loadCh(1, 0, "load1");
    for (int k = 0; k < 8; k++) step("fast1");

    // Stall ch0 at cnt 2 for five cycles, then resume from the held count.
    for (int k = 0; k < 8 && (mN[0] % (mDiv[0] + 1)) != 2; k++) step("align0");
    check("align0.reached", 32'(mN[0] % (mDiv[0] + 1)), 32'd2);
    ien[0] = 1'b0;
    for (int k = 0; k < 5; k++) step("hold0");
    ien[0] = 1'b1;
    for (int k = 0; k < 6; k++) step("resume0");

    // Divisors 2,3,5 then a resync: ticks at 3,4,6 edges after it.
    loadCh(0, 2, "load0");
    loadCh(1, 3, "load1b");
    loadCh(2, 5, "load2");
    for (int k = 0; k < 4; k++) step("pre_sync");
    isync = 1'b1;
    step("sync");
    for (int k = 0; k < 14; k++) step("post_sync");

    // Load and sync on the same edge, then an out-of-range select.
    for (int k = 0; k < 2; k++) step("pre_both");
    iload = 1'b1; ich = 2'd0; idiv = 8'd4; isync = 1'b1;
    step("load_sync");
    for (int k = 0; k < 8; k++) step("after_both");
    loadCh(N_CH, 0, "bad_ch");
    for (int k = 0; k < 8; k++) step("after_bad");

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N_CH; i++) ien[i] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) begin
        iload = 1'b1;
        ich   = CH_W'($urandom_range(0, 3));
        idiv  = DIV_W'($urandom_range(0, 7));
      end
      isync = ($urandom_range(0, 39) == 0);
      step("rand");
    end

    // Asynchronous reset mid-cycle while ch0 is high.
    ien = '1;
    loadCh(0, 3, "pre_arst");
    for (int k = 0; k < 20; k++) begin
`ifdef TICKGEN_SQUARE_EN
      if (expSq[0]) break;
`else
      if (expTick[0]) break;
`endif
      step("seek_high");
    end
`ifdef TICKGEN_SQUARE_EN
    check("arst.pre_osq", 32'(osq[0]), 32'd1);
`else
    check("arst.pre_tick", 32'(otick[0]), 32'd1);
`endif
    #2 irst = 1'b0;
    #1;
    check("arst.otick", 32'(otick), 32'd0);
`ifdef TICKGEN_SQUARE_EN
    check("arst.osq", 32'(osq), 32'd0);
`endif
    @(negedge iclk);
    irst = 1'b1;
    modelReset();
    for (int k = 0; k < 10; k++) step("post_arst");

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
